// File: rtl/uart_rx_fsm.sv
// UART receiver control FSM: start detection, oversample/bit counters, checker enables, frame accept.
// Optional error pulses (par_err_pulse, stp_err_pulse) are built when UART_RX_ERR_PULSE_EN is defined.
module uart_rx_fsm #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic                      PAR_EN,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic                      start_glitch,
  input  logic                      parity_error,
  input  logic                      stop_error,
  output logic                      data_sample_enable,
  output logic                      start_checker_enable,
  output logic                      deserializer_enable,
  output logic                      parity_checker_enable,
  output logic                      stop_checker_enable,
  output logic [PRESCALE_WIDTH-1:0] edge_cnt,
  output logic [3:0]                bit_cnt,
  output logic                      data_valid
`ifdef UART_RX_ERR_PULSE_EN
  ,
  output logic                      par_err_pulse,
  output logic                      stp_err_pulse
`endif
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [3:0] LAST_DATA = 4'(DATA_WIDTH);

  state_t                    state, state_nxt;
  logic [PRESCALE_WIDTH-1:0] presc_q;
  logic                      par_en_q;
  logic [PRESCALE_WIDTH-1:0] check_pt;
  logic                      bit_end;
  logic                      at_cp;

  // Check point sits one cycle after the sampler registers its majority vote.
  assign check_pt = (presc_q >> 1) + PRESCALE_WIDTH'(2);
  assign bit_end  = (edge_cnt == presc_q - PRESCALE_WIDTH'(1));
  assign at_cp    = (edge_cnt == check_pt);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      edge_cnt <= '0;
      bit_cnt  <= '0;
      presc_q  <= '0;
      par_en_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        edge_cnt <= '0;
        bit_cnt  <= '0;
        if (!RX_IN) begin
          presc_q  <= Prescale;
          par_en_q <= PAR_EN;
        end
      end else if (bit_end) begin
        edge_cnt <= '0;
        bit_cnt  <= (state_nxt == IDLE) ? 4'd0 : bit_cnt + 4'd1;
      end else begin
        edge_cnt <= edge_cnt + PRESCALE_WIDTH'(1);
      end
    end
  end

  always_comb begin
    state_nxt             = state;
    data_sample_enable    = 1'b0;
    start_checker_enable  = 1'b0;
    deserializer_enable   = 1'b0;
    parity_checker_enable = 1'b0;
    stop_checker_enable   = 1'b0;
    data_valid            = 1'b0;
`ifdef UART_RX_ERR_PULSE_EN
    par_err_pulse         = 1'b0;
    stp_err_pulse         = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!RX_IN) state_nxt = START;
      end
      START: begin
        data_sample_enable   = 1'b1;
        start_checker_enable = at_cp;
        if (bit_end) state_nxt = start_glitch ? IDLE : DATA;
      end
      DATA: begin
        data_sample_enable  = 1'b1;
        deserializer_enable = at_cp;
        if (bit_end && bit_cnt == LAST_DATA) state_nxt = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        data_sample_enable    = 1'b1;
        parity_checker_enable = at_cp;
        if (bit_end) begin
          state_nxt = parity_error ? IDLE : STOP;
`ifdef UART_RX_ERR_PULSE_EN
          par_err_pulse = parity_error;
`endif
        end
      end
      STOP: begin
        data_sample_enable  = 1'b1;
        stop_checker_enable = at_cp;
        if (bit_end) begin
          state_nxt  = IDLE;
          data_valid = !stop_error;
`ifdef UART_RX_ERR_PULSE_EN
          stp_err_pulse = stop_error;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/uart_rx_fsm.md
Name: uart_rx_fsm

Overview:
- Control FSM of the UART receiver.
- Detects the falling start edge and runs the oversampling edge counter and bit counter.
- Issues one-cycle enable pulses to the data sampler, start checker, deserializer, parity checker and stop checker, then evaluates their error flags.
- Raises data_valid for each clean frame. Sits between the RX_IN pin logic and the per-bit checker/deserializer stages.

Parameters:
- DATA_WIDTH, 8, data bits per frame (LSB first).
- PRESCALE_WIDTH, 6, width of the Prescale input and edge_cnt.

Ports:
- CLK  input  1  oversampling clock
- RST  input  1  asynchronous active-low reset
- RX_IN  input  1  serial line, idle high
- PAR_EN  input  1  1 = frame carries a parity bit
- Prescale  input  PRESCALE_WIDTH  oversampling ratio; legal values 8, 16, 32
- start_glitch  input  1  start checker result, registered
- parity_error  input  1  parity checker result, registered
- stop_error  input  1  stop checker result, registered
- data_sample_enable  output  1  sampler runs while high
- start_checker_enable  output  1  one-cycle pulse
- deserializer_enable  output  1  one-cycle pulse per data bit
- parity_checker_enable  output  1  one-cycle pulse
- stop_checker_enable  output  1  one-cycle pulse
- edge_cnt  output  PRESCALE_WIDTH  oversample index within the current bit
- bit_cnt  output  4  bit index within the frame
- data_valid  output  1  one-cycle pulse, frame accepted

Behaviour:
- Reset: all outputs are 0 and state is IDLE. Async reset mid-frame aborts the frame immediately; no data_valid is issued for it.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - Counters are held at 0 and data_sample_enable is 0.
  - RX_IN==0 in any cycle moves to START next cycle, with edge_cnt=0 and bit_cnt=0.
  - Prescale and PAR_EN are latched on that transition. Later changes take effect only at the next frame.
- Non-IDLE states:
  - data_sample_enable is 1.
  - edge_cnt increments every cycle. At latched Prescale-1 it wraps to 0 and bit_cnt increments. The cycle where edge_cnt == Prescale-1 is "bit end".
- Check point CP = Prescale/2 + 2, the first cycle after the sampler's majority result is registered.
- At edge_cnt==CP the state issues its enable:
  - START: start_checker_enable.
  - DATA: deserializer_enable.
  - PARITY: parity_checker_enable.
  - STOP: stop_checker_enable.
  - The checker flag is valid from CP+1 and is read by the FSM at bit end.
- Transitions at bit end:
  - START: start_glitch=1 goes to IDLE; otherwise goes to DATA.
  - DATA: goes to PARITY when bit_cnt==DATA_WIDTH and latched PAR_EN=1; goes to STOP when bit_cnt==DATA_WIDTH and PAR_EN=0; otherwise stays in DATA.
  - PARITY: parity_error=1 goes to IDLE and the frame is dropped; otherwise goes to STOP.
  - STOP: always goes to IDLE. data_valid=1 in that same bit-end cycle iff stop_error==0. This is the only cycle data_valid can be high.
- bit_cnt encoding:
  - 0 = start bit.
  - 1..DATA_WIDTH = data bits.
  - DATA_WIDTH+1 = parity (if enabled).
  - Next value = stop.
  - Returns to 0 in IDLE.
- Back-to-back frames: the start edge arriving in the cycle after STOP bit end is detected from IDLE with one cycle of latency. Required because the start checker tolerates a 1-cycle offset.
- RX_IN low for a whole frame (break): stop_error=1, so no data_valid. FSM returns to IDLE, then re-enters START while the line stays low.
- Illegal Prescale: behaviour undefined; not checked by the block.

Optional Feature:
- Macro: UART_RX_ERR_PULSE_EN.
- With it defined, two extra 1-bit outputs are present:
  - par_err_pulse: one-cycle pulse at the PARITY bit end when parity_error=1.
  - stp_err_pulse: one-cycle pulse at the STOP bit end when stop_error=1.
  - Both reset to 0.
- Without it, these ports and their logic do not exist. All other behaviour is identical.

Test Plan:
- Prescale=8, PAR_EN=0, frame 0xA5 with valid stop -> deserializer_enable pulses 8 times at edge_cnt=6; stop_checker_enable at bit_cnt=9; data_valid one cycle at frame cycle 79 (10 bits x 8 - 1).
- Prescale=16, PAR_EN=1, even parity correct, stop bit driven 0 -> stop_error=1, no data_valid; stp_err_pulse=1 (macro on); FSM back to IDLE.
- Prescale=8, RX_IN low for 3 cycles then high (start_glitch=1) -> START to IDLE at edge_cnt=7, no deserializer_enable, bit_cnt=0.
- Prescale=32, PAR_EN=1, parity_error=1 -> no stop_checker_enable, no data_valid; par_err_pulse=1 (macro on).
- Two back-to-back 0x3C frames, Prescale=8 -> two data_valid pulses 81 cycles apart.
- RST low at bit_cnt=4 of a frame -> all outputs 0 asynchronously; next clean frame after reset yields one data_valid.
